// File: rtl/esc_receiver.sv
// Escalation receiver: decodes differential ping/escalation from the sender, answers it and raises esc_req_o.
// Latency: response one cycle after the sampled input; escalation request two cycles after escalation starts.
// Backpressure: none; the sender's level is sampled every cycle. esc_tx_i = {esc_p, esc_n}, esc_rx_o = {resp_p, resp_n}.
module esc_receiver #(
    parameter int unsigned TimeoutCntDw = 16,
    parameter bit          TimeoutEn    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] esc_tx_i,
    output logic [1:0] esc_rx_o,
    output logic       esc_req_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ESC    = 2'd2,
        SIGINT = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   tog_q, tog_d;
    logic   esc_p, esc_n;
    logic   valid, active, sigint;
    logic   fsm_req;
    logic   timeout;
    logic   enter_esc, ping_done;

    assign esc_p  = esc_tx_i[1];
    assign esc_n  = esc_tx_i[0];
    assign valid  = esc_p != esc_n;
    assign active = valid & esc_p;
    assign sigint = ~valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (active) state_d = CHECK;
            CHECK:   if (active) state_d = ESC;
                     else        state_d = IDLE;
            ESC:     if (!active) state_d = IDLE;
            SIGINT:  if (active) state_d = ESC;
                     else        state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A broken differential pair wins over every other transition.
        if (sigint) state_d = SIGINT;
    end

    assign enter_esc = (state_d == ESC) && (state_q != ESC);
    assign ping_done = (state_q == CHECK) && (state_d == IDLE);

    always_comb begin
        tog_d = 1'b0;
        if (enter_esc) begin
            tog_d = 1'b0;
        end else if (state_d == SIGINT && state_q != SIGINT) begin
            tog_d = 1'b1;
        end else if (state_q == ESC || state_q == SIGINT) begin
            tog_d = ~tog_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
        end
    end

    always_comb begin
        esc_rx_o = 2'b01;
        fsm_req  = 1'b0;
        case (state_q)
            CHECK:  esc_rx_o = 2'b10;
            ESC: begin
                esc_rx_o = {tog_q, ~tog_q};
                fsm_req  = 1'b1;
            end
            SIGINT: begin
                esc_rx_o = {tog_q, tog_q};
                fsm_req  = 1'b1;
            end
            default: esc_rx_o = 2'b01;
        endcase
    end

    if (TimeoutEn) begin : g_timeout
        localparam logic [TimeoutCntDw-1:0] CntMax = '1;
        logic [TimeoutCntDw-1:0] cnt_q;
        logic                    tmo_q;

        // Counts idle cycles since the last completed ping or escalation; the flag is sticky until reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else begin
                tmo_q <= tmo_q | (cnt_q == CntMax);
                if (ping_done || enter_esc) begin
                    cnt_q <= '0;
                end else if (state_q == IDLE && cnt_q != CntMax) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign timeout = tmo_q;
    end else begin : g_no_timeout
        assign timeout = 1'b0;
    end

    assign esc_req_o = fsm_req | timeout;

endmodule

// File: tb/tb_esc_receiver.sv
// Bench for esc_receiver: three instances (default width, 4-bit timeout, 4-bit with timeout disabled) on shared stimulus.
module tb_esc_receiver;

    logic       clk;
    logic       rst_n;
    logic [1:0] esc_tx;
    logic [1:0] rx  [3];
    logic       req [3];

    esc_receiver dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .esc_tx_i (esc_tx),
        .esc_rx_o (rx[0]),
        .esc_req_o(req[0])
    );

    esc_receiver #(.TimeoutCntDw(4), .TimeoutEn(1'b1)) dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .esc_tx_i (esc_tx),
        .esc_rx_o (rx[1]),
        .esc_req_o(req[1])
    );

    esc_receiver #(.TimeoutCntDw(4), .TimeoutEn(1'b0)) dut_c (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .esc_tx_i (esc_tx),
        .esc_rx_o (rx[2]),
        .esc_req_o(req[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the response is a function of the run of identical input classes just seen.
    int sig_run, act_run;
    bit act_after_sig;
    int m_cnt [3];
    bit m_tmo [3];
    int mmax  [3];
    bit men   [3];

    function automatic int phase_of(input int s, input int a, input bit aas);
        if (s > 0) return 3;
        if (a > 0) return (aas || a > 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [1:0] exp_rx();
        int n;
        n = act_after_sig ? act_run : act_run - 1;
        case (phase_of(sig_run, act_run, act_after_sig))
            3:       return (sig_run % 2 == 1) ? 2'b11 : 2'b00;
            2:       return (n % 2 == 1) ? 2'b01 : 2'b10;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic exp_req(input int i);
        return (phase_of(sig_run, act_run, act_after_sig) >= 2) || m_tmo[i];
    endfunction

    task automatic model_reset();
        sig_run = 0;
        act_run = 0;
        act_after_sig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_tmo[i] = 1'b0;
        end
    endtask

    task automatic model_update(input logic [1:0] tx);
        int pb, pa;
        bit nt;
        pb = phase_of(sig_run, act_run, act_after_sig);
        if (tx == 2'b00 || tx == 2'b11) begin
            sig_run++;
            act_run = 0;
            act_after_sig = 1'b0;
        end else if (tx == 2'b10) begin
            if (act_run == 0) act_after_sig = (sig_run > 0);
            act_run++;
            sig_run = 0;
        end else begin
            sig_run = 0;
            act_run = 0;
            act_after_sig = 1'b0;
        end
        pa = phase_of(sig_run, act_run, act_after_sig);
        for (int i = 0; i < 3; i++) begin
            if (men[i]) begin
                nt = m_tmo[i] || (m_cnt[i] == mmax[i]);
                if ((pb == 1 && pa == 0) || (pa == 2 && pb != 2)) m_cnt[i] = 0;
                else if (pb == 0 && m_cnt[i] < mmax[i]) m_cnt[i]++;
                m_tmo[i] = nt;
            end
        end
    endtask

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_rx[%0d]", i), rx[i], exp_rx());
            check($sformatf("model_req[%0d]", i), {1'b0, req[i]}, {1'b0, exp_req(i)});
        end
    endtask

    task automatic step(input logic [1:0] tx);
        esc_tx = tx;
        @(posedge clk);
        #1;
        model_update(tx);
        check_model();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        esc_tx = 2'b01;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rx[%0d]", i), rx[i], 2'b01);
            check($sformatf("reset_req[%0d]", i), {1'b0, req[i]}, 2'b00);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] tx;
        logic [1:0] rx;
        logic       req;
    } vec_t;

    vec_t tbl [20];

    initial begin
        mmax[0] = 65535; men[0] = 1'b1;
        mmax[1] = 15;    men[1] = 1'b1;
        mmax[2] = 15;    men[2] = 1'b0;

        // ping, back-to-back ping, 6-cycle escalation, integrity errors, sigint->esc->sigint
        tbl[0]  = '{2'b01, 2'b01, 1'b0};
        tbl[1]  = '{2'b10, 2'b10, 1'b0};
        tbl[2]  = '{2'b01, 2'b01, 1'b0};
        tbl[3]  = '{2'b10, 2'b10, 1'b0};
        tbl[4]  = '{2'b01, 2'b01, 1'b0};
        tbl[5]  = '{2'b10, 2'b10, 1'b0};
        tbl[6]  = '{2'b10, 2'b01, 1'b1};
        tbl[7]  = '{2'b10, 2'b10, 1'b1};
        tbl[8]  = '{2'b10, 2'b01, 1'b1};
        tbl[9]  = '{2'b10, 2'b10, 1'b1};
        tbl[10] = '{2'b10, 2'b01, 1'b1};
        tbl[11] = '{2'b01, 2'b01, 1'b0};
        tbl[12] = '{2'b11, 2'b11, 1'b1};
        tbl[13] = '{2'b11, 2'b00, 1'b1};
        tbl[14] = '{2'b11, 2'b11, 1'b1};
        tbl[15] = '{2'b10, 2'b01, 1'b1};
        tbl[16] = '{2'b11, 2'b11, 1'b1};
        tbl[17] = '{2'b01, 2'b01, 1'b0};
        tbl[18] = '{2'b00, 2'b11, 1'b1};
        tbl[19] = '{2'b01, 2'b01, 1'b0};

        rst_n  = 1'b1;
        esc_tx = 2'b01;
        #2;
        do_reset();

        for (int k = 0; k < 20; k++) begin
            step(tbl[k].tx);
            check($sformatf("tbl_rx[%0d]", k), rx[0], tbl[k].rx);
            check($sformatf("tbl_req[%0d]", k), {1'b0, req[0]}, {1'b0, tbl[k].req});
        end

        // Timeout with a 4-bit counter: fires on the 16th idle cycle and survives later pings.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(2'b01);
            check($sformatf("tmo_req_c%0d", i), {1'b0, req[1]}, {1'b0, (i == 16)});
        end
        step(2'b10);
        check("tmo_ping_rx", rx[1], 2'b10);
        check("tmo_ping_req", {1'b0, req[1]}, 2'b01);
        step(2'b01);
        step(2'b01);
        check("tmo_sticky", {1'b0, req[1]}, 2'b01);
        check("tmo_disabled", {1'b0, req[2]}, 2'b00);

        // Regular pings every 10 cycles keep the 4-bit timeout quiet.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            step((c % 10 == 0) ? 2'b10 : 2'b01);
            check($sformatf("avoid_req_c%0d", c), {1'b0, req[1]}, 2'b00);
        end

        // Reset in the middle of an escalation acts before the next clock edge.
        step(2'b10);
        step(2'b10);
        step(2'b10);
        step(2'b10);
        check("mid_esc_req", {1'b0, req[0]}, 2'b01);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_rst_rx[%0d]", i), rx[i], 2'b01);
            check($sformatf("async_rst_req[%0d]", i), {1'b0, req[i]}, 2'b00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b10);
        check("post_rst_check", rx[0], 2'b10);
        step(2'b01);

        // Randomized traffic against the model, with forced idle windows to provoke timeouts.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c % 750 == 749) do_reset();
            r = $urandom_range(0, 19);
            if (c % 750 >= 300 && c % 750 < 340) step(2'b01);
            else if (r == 0) step(2'b00);
            else if (r == 1) step(2'b11);
            else if (r < 8)  step(2'b10);
            else             step(2'b01);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
